sdram_init_ctrl: RTL and testbench



---
 rtl/sdram_pkg.sv | 40 ++++
 rtl/sdram_init_ctrl.sv | 89 ++++++++
 tb/tb_sdram_init_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, init FSM states and default timings
// used by the init, refresh and read/write controllers.
package sdram_pkg;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;

  localparam int unsigned T_POWER_DEF = 20000;
  localparam int unsigned T_RP_DEF    = 2;
  localparam int unsigned T_RFC_DEF   = 7;
  localparam int unsigned T_MRD_DEF   = 3;
  localparam int unsigned REF_NUM_DEF = 8;

  localparam logic [11:0] MODE_VALUE_DEF = 12'b000_0_00_011_0_111;

  typedef enum logic [2:0] {
    S_WAIT_PWR,
    S_PRE,
    S_WAIT_RP,
    S_AREF,
    S_WAIT_RFC,
    S_LMR,
    S_WAIT_MRD,
    S_DONE
  } init_state_e;

  // A wait state is entered one cycle after its command, with the counter cleared on
  // each state change, so the next command lands exactly t cycles after the previous one
  // when the wait exits at cnt == t - 2 (t >= 2).
  function automatic logic wait_over(input logic [15:0] cnt, input int unsigned t);
    return ({16'd0, cnt} + 32'd2) >= t;
  endfunction

endpackage

// File: rtl/sdram_init_ctrl.sv
// SDRAM power-up sequencer: power wait, precharge-all, REF_NUM auto-refreshes,
// load-mode, then a sticky init_done. Outputs are registered from the next state.
module sdram_init_ctrl
  import sdram_pkg::*;
#(
  parameter int unsigned T_POWER    = T_POWER_DEF,
  parameter int unsigned T_RP       = T_RP_DEF,
  parameter int unsigned T_RFC      = T_RFC_DEF,
  parameter int unsigned T_MRD      = T_MRD_DEF,
  parameter int unsigned REF_NUM    = REF_NUM_DEF,
  parameter logic [11:0] MODE_VALUE = MODE_VALUE_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  output logic [3:0]  init_cmd_out,
  output logic [1:0]  init_bank_out,
  output logic [11:0] init_addr_out,
  output logic        init_done
);

  localparam logic [15:0] TPower = 16'(T_POWER);
  localparam logic [3:0]  RefNum = 4'(REF_NUM);

  init_state_e state, state_d;
  logic [15:0] cnt;
  logic [3:0]  ref_cnt;

  logic [3:0]  cmd_d;
  logic [1:0]  bank_d;
  logic [11:0] addr_d;

  always_comb begin
    state_d = state;
    unique case (state)
      S_WAIT_PWR: if (cnt >= TPower) state_d = S_PRE;
      S_PRE:      state_d = S_WAIT_RP;
      S_WAIT_RP:  if (wait_over(cnt, T_RP)) state_d = S_AREF;
      S_AREF:     state_d = S_WAIT_RFC;
      S_WAIT_RFC: if (wait_over(cnt, T_RFC)) state_d = (ref_cnt < RefNum) ? S_AREF : S_LMR;
      S_LMR:      state_d = S_WAIT_MRD;
      S_WAIT_MRD: if (wait_over(cnt, T_MRD)) state_d = S_DONE;
      S_DONE:     state_d = S_DONE;
      default:    state_d = S_WAIT_PWR;
    endcase
  end

  always_comb begin
    cmd_d  = CMD_NOP;
    bank_d = 2'b11;
    addr_d = 12'hFFF;
    unique case (state_d)
      S_PRE:  cmd_d = CMD_PRE;
      S_AREF: cmd_d = CMD_AREF;
      S_LMR: begin
        cmd_d  = CMD_LMR;
        bank_d = 2'b00;
        addr_d = MODE_VALUE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= S_WAIT_PWR;
      cnt           <= '0;
      ref_cnt       <= '0;
      init_cmd_out  <= CMD_NOP;
      init_bank_out <= 2'b11;
      init_addr_out <= 12'hFFF;
      init_done     <= 1'b0;
    end else begin
      state <= state_d;
      if (state_d != state) begin
        cnt <= '0;
      end else if (state != S_DONE) begin
        cnt <= cnt + 16'd1;
      end
      if (state_d == S_AREF && state != S_AREF) begin
        ref_cnt <= ref_cnt + 4'd1;
      end
      init_cmd_out  <= cmd_d;
      init_bank_out <= bank_d;
      init_addr_out <= addr_d;
      init_done     <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_sdram_init_ctrl.sv
// Directed bench for sdram_init_ctrl: default-parameter and short-parameter instances,
// per-cycle comparison of the command/bank/address/done bundle against the schedule.
module tb_sdram_init_ctrl;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] LMR  = 4'b0000;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;

  logic [3:0]  cmd_a, cmd_b;
  logic [1:0]  bank_a, bank_b;
  logic [11:0] addr_a, addr_b;
  logic        done_a, done_b;

  int n_checks = 0;
  int n_fail   = 0;
  int n_aref_a = 0;

  always #5 sys_clk = ~sys_clk;

  sdram_init_ctrl u_dut_a (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .init_cmd_out (cmd_a),
    .init_bank_out(bank_a),
    .init_addr_out(addr_a),
    .init_done    (done_a)
  );

  sdram_init_ctrl #(
    .T_POWER(10),
    .REF_NUM(2),
    .T_RFC  (4)
  ) u_dut_b (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .init_cmd_out (cmd_b),
    .init_bank_out(bank_b),
    .init_addr_out(addr_b),
    .init_done    (done_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected {cmd, bank, addr, done} from the documented command schedule.
  function automatic logic [18:0] exp_vec(input int c, input int tp, input int trp,
                                          input int trfc, input int tmrd, input int refn,
                                          input logic [11:0] mode);
    logic [3:0]  cmd;
    logic [1:0]  bank;
    logic [11:0] addr;
    int          lmr;
    cmd  = NOP;
    bank = 2'b11;
    addr = 12'hFFF;
    lmr  = tp + trp + refn * trfc;
    if (c == tp) cmd = PRE;
    for (int k = 1; k <= refn; k++) begin
      if (c == tp + trp + (k - 1) * trfc) cmd = AREF;
    end
    if (c == lmr) begin
      cmd  = LMR;
      bank = 2'b00;
      addr = mode;
    end
    return {cmd, bank, addr, (c >= lmr + tmrd) ? 1'b1 : 1'b0};
  endfunction

  function automatic logic [31:0] vec_a();
    return {13'd0, cmd_a, bank_a, addr_a, done_a};
  endfunction

  function automatic logic [31:0] vec_b();
    return {13'd0, cmd_b, bank_b, addr_b, done_b};
  endfunction

  task automatic check_reset(input string tag);
    check_eq({tag, "_a"}, vec_a(), {13'd0, NOP, 2'b11, 12'hFFF, 1'b0});
    check_eq({tag, "_b"}, vec_b(), {13'd0, NOP, 2'b11, 12'hFFF, 1'b0});
  endtask

  // Runs cycles 0..last after a release, comparing both instances every cycle.
  task automatic run_cycles(input int last);
    for (int c = 0; c <= last; c++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      check_eq($sformatf("a_c%0d", c), vec_a(),
               {13'd0, exp_vec(c, 20000, 2, 7, 3, 8, 12'h037)});
      check_eq($sformatf("b_c%0d", c), vec_b(),
               {13'd0, exp_vec(c, 10, 2, 4, 3, 2, 12'h037)});
      if (cmd_a == AREF) n_aref_a++;
      if (c == 20000) check_eq("a_pre_a10", {31'd0, addr_a[10]}, 32'd1);
      if (c == 20058) check_eq("a_lmr_addr", {20'd0, addr_a}, 32'h037);
      if (c == 20061) check_eq("a_done_rise", {31'd0, done_a}, 32'd1);
      if (c == 23)    check_eq("b_done_rise", {31'd0, done_b}, 32'd1);
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      check_reset($sformatf("rst%0d", i));
    end
    sys_rst = 1'b0;
    run_cycles(20161);
    check_eq("a_aref_count", n_aref_a, 32'd8);

    // Reset after done, then a mid-refresh pulse at cycle 20030.
    sys_rst = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check_reset("rst_after_done");
    sys_rst = 1'b0;
    run_cycles(20029);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check_reset("rst_mid_ref");
    sys_rst = 1'b0;
    n_aref_a = 0;
    run_cycles(20065);
    check_eq("a_aref_count_restart", n_aref_a, 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
